// File: rtl/bypass_credits_wr_if.sv
// Shared request type and valid/ready metadata interface
// for the Bypass TX credit gate.
package bypass_pkg;
  localparam int AXI_DATA_BITS = 512;
  localparam int VADDR_BITS = 48;
  localparam int LEN_BITS = 28;
  localparam int DEST_BITS = 4;

  typedef struct packed {
    logic [VADDR_BITS-1:0] vaddr;
    logic [LEN_BITS-1:0]   len;
    logic [DEST_BITS-1:0]  dest;
    logic                  ctl;
  } req_t;
endpackage

interface metaIntf;
  import bypass_pkg::*;
  logic valid;
  logic ready;
  req_t data;

  modport s (
    input  valid,
    input  data,
    output ready
  );

  modport m (
    output valid,
    output data,
    input  ready
  );
endinterface

// File: rtl/bypass_credits_wr.sv
// Bypass write credit gate: holds a request until its
// data beats are buffered downstream, then forwards it.
module bypass_credits_wr
  import bypass_pkg::*;
#(
  parameter int DATA_BITS = AXI_DATA_BITS,
  parameter int BUF_BEATS = 512,
  parameter int CRED_BITS = $clog2(BUF_BEATS+1)
) (
  input  logic                 aclk,
  input  logic                 areset,
  metaIntf.s                   s_req,
  metaIntf.m                   m_req,
  input  logic                 xfer,
  output logic [CRED_BITS-1:0] cred_cnt,
  output logic                 ovf,
  output logic                 err
);

  localparam int BEAT_LOG_BITS = $clog2(DATA_BITS/8);
  localparam int SH_BITS = LEN_BITS - BEAT_LOG_BITS;
  localparam int NB = SH_BITS + 1;
  localparam int SW = ((NB > CRED_BITS) ? NB : CRED_BITS) + 1;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t state_C, state_N;

  req_t req_C;
  req_t out_C;
  logic out_vld_C;

  logic [NB-1:0]        beats_C;
  logic [NB-1:0]        n_beats;
  logic [SH_BITS-1:0]   len_sh;
  logic [CRED_BITS-1:0] cred_C;
  logic [CRED_BITS-1:0] cred_N;
  logic [SW-1:0]        cred_sum;

  logic s_rdy;
  logic hs;
  logic too_big;
  logic out_free;
  logic cred_ok;
  logic issue;
  logic clamp;

  // Beat count of the offered request; len 0 counts as one beat
  always_comb begin
    len_sh = SH_BITS'((s_req.data.len - LEN_BITS'(1)) >> BEAT_LOG_BITS);
    if (s_req.data.len == '0) begin
      n_beats = NB'(1);
    end else begin
      n_beats = {1'b0, len_sh} + NB'(1);
    end
    too_big = SW'(n_beats) > SW'(BUF_BEATS);
  end

  assign hs       = s_req.valid && s_rdy;
  assign out_free = !out_vld_C || m_req.ready;
  assign cred_ok  = SW'(cred_C) >= SW'(beats_C);

  // Next state, input ready and issue decision
  always_comb begin
    state_N = state_C;
    s_rdy   = 1'b0;
    issue   = 1'b0;
    unique case (state_C)
      ST_IDLE: begin
        s_rdy = 1'b1;
        if (s_req.valid && !too_big) begin
          state_N = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cred_ok && out_free) begin
          issue   = 1'b1;
          state_N = ST_IDLE;
        end
      end
      default: ;
    endcase
  end

  // Credit arithmetic with saturation at buffer capacity
  always_comb begin
    cred_sum = SW'(cred_C) + SW'(xfer)
             - (issue ? SW'(beats_C) : SW'(0));
    clamp = cred_sum > SW'(BUF_BEATS);
    if (clamp) begin
      cred_N = CRED_BITS'(BUF_BEATS);
    end else begin
      cred_N = cred_sum[CRED_BITS-1:0];
    end
  end

  // State register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_C <= ST_IDLE;
    end else begin
      state_C <= state_N;
    end
  end

  // Capture the pending request and its beat count
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      req_C   <= '0;
      beats_C <= '0;
    end else if (hs) begin
      req_C   <= s_req.data;
      beats_C <= n_beats;
    end
  end

  // Credit counter and sticky error flags
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cred_C <= '0;
      ovf    <= 1'b0;
      err    <= 1'b0;
    end else begin
      cred_C <= cred_N;
      if (clamp) begin
        ovf <= 1'b1;
      end
      if (hs && too_big) begin
        err <= 1'b1;
      end
    end
  end

  // Output register; refills in the cycle the held entry drains
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      out_vld_C <= 1'b0;
      out_C     <= '0;
    end else if (issue) begin
      out_vld_C <= 1'b1;
      out_C     <= req_C;
    end else if (m_req.ready) begin
      out_vld_C <= 1'b0;
    end
  end

  assign s_req.ready = s_rdy;
  assign m_req.valid = out_vld_C;
  assign m_req.data  = out_C;
  assign cred_cnt    = cred_C;

endmodule

// File: tb/tb_bypass_credits_wr.sv
// Scoreboard bench for bypass_credits_wr: directed
// stimulus, forwarded requests checked in arrival order.
module tb_bypass_credits_wr;
  import bypass_pkg::*;

  logic       aclk = 1'b0;
  logic       areset;
  logic       xfer;
  logic [9:0] cred_cnt;
  logic       ovf;
  logic       err;

  metaIntf s_req_if ();
  metaIntf m_req_if ();

  bypass_credits_wr dut (
    .aclk     (aclk),
    .areset   (areset),
    .s_req    (s_req_if),
    .m_req    (m_req_if),
    .xfer     (xfer),
    .cred_cnt (cred_cnt),
    .ovf      (ovf),
    .err      (err)
  );

  always #5 aclk = ~aclk;

  int   checks = 0;
  int   errors = 0;
  req_t exp_q[$];
  req_t mon_e;
  bit   seen;

  int lens[4] = '{1, 64, 65, 0};
  int creds[4] = '{7, 6, 4, 3};

  function automatic req_t mk(input logic [27:0] len,
                              input logic [47:0] tag);
    req_t r;
    r       = '0;
    r.len   = len;
    r.vaddr = tag;
    r.dest  = tag[3:0];
    r.ctl   = tag[0];
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic xfers(input int n);
    xfer = 1'b1;
    repeat (n) tick();
    xfer = 1'b0;
  endtask

  task automatic send(input logic [27:0] len,
                      input logic [47:0] tag,
                      input bit          fwd);
    int w;
    w = 0;
    s_req_if.data  = mk(len, tag);
    s_req_if.valid = 1'b1;
    while (!s_req_if.ready && w < 200) begin
      tick();
      w++;
    end
    chk("send_ready", s_req_if.ready, 1);
    if (s_req_if.ready) begin
      if (fwd) exp_q.push_back(mk(len, tag));
      tick();
    end
    s_req_if.valid = 1'b0;
  endtask

  task automatic watch(input int n);
    seen = 0;
    repeat (n) begin
      if (m_req_if.valid) seen = 1;
      tick();
    end
  endtask

  // Monitor: every accepted output must match the next expected
  always @(negedge aclk) begin
    if (!areset && m_req_if.valid && m_req_if.ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL m_req_unexpected act=%0h exp=none",
                 m_req_if.data);
      end else begin
        mon_e = exp_q.pop_front();
        if (m_req_if.data !== mon_e) begin
          errors++;
          $display("FAIL m_req_data act=%0h exp=%0h",
                   m_req_if.data, mon_e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    areset            = 1'b1;
    xfer              = 1'b0;
    s_req_if.valid    = 1'b0;
    s_req_if.data     = '0;
    m_req_if.ready    = 1'b1;
    #2;
    chk("rst_mvalid", m_req_if.valid, 0);
    chk("rst_cred", cred_cnt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_err", err, 0);
    chk("rst_sready", s_req_if.ready, 1);
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    tick();

    // basic gating
    send(256, 48'hA1, 1);
    watch(100);
    chk("gate_hold", seen, 0);
    chk("gate_cred0a", cred_cnt, 0);
    xfers(4);
    chk("gate_cred4", cred_cnt, 4);
    chk("gate_vpre", m_req_if.valid, 0);
    tick();
    chk("gate_valid", m_req_if.valid, 1);
    chk("gate_cred0b", cred_cnt, 0);
    tick();

    // length rounding
    xfers(8);
    chk("rnd_pre", cred_cnt, 8);
    for (int i = 0; i < 4; i++) begin
      send(28'(lens[i]), 48'hB0 + 48'(i), 1);
      tick();
      chk($sformatf("rnd_cred%0d", i), cred_cnt, creds[i]);
    end

    // simultaneous xfer and issue
    xfers(1);
    chk("sim_pre", cred_cnt, 4);
    send(256, 48'hC0, 1);
    xfer = 1'b1;
    tick();
    xfer = 1'b0;
    chk("sim_cred", cred_cnt, 1);
    tick();

    // backpressure
    xfers(9);
    chk("bp_pre", cred_cnt, 10);
    m_req_if.ready = 1'b0;
    send(64, 48'hD0, 1);
    send(1, 48'hD1, 1);
    repeat (3) tick();
    chk("bp_sready", s_req_if.ready, 0);
    chk("bp_valid", m_req_if.valid, 1);
    chk("bp_data", m_req_if.data, mk(64, 48'hD0));
    chk("bp_cred9", cred_cnt, 9);
    repeat (5) tick();
    chk("bp_stable", m_req_if.data, mk(64, 48'hD0));
    m_req_if.ready = 1'b1;
    repeat (3) tick();
    chk("bp_cred8", cred_cnt, 8);
    chk("bp_drained", exp_q.size(), 0);

    // overflow
    xfers(504);
    chk("ovf_full", cred_cnt, 512);
    chk("ovf_clear", ovf, 0);
    xfers(1);
    chk("ovf_sat", cred_cnt, 512);
    chk("ovf_set", ovf, 1);

    // oversize request
    chk("err_clear", err, 0);
    send(32832, 48'hE0, 0);
    chk("err_set", err, 1);
    chk("err_sready", s_req_if.ready, 1);
    watch(10);
    chk("err_novalid", seen, 0);
    send(32768, 48'hE1, 1);
    tick();
    chk("err_next_cred", cred_cnt, 0);
    tick();

    // reset mid-operation
    m_req_if.ready = 1'b0;
    xfers(8);
    send(1, 48'hF0, 1);
    tick();
    chk("mr_valid", m_req_if.valid, 1);
    chk("mr_cred7", cred_cnt, 7);
    areset = 1'b1;
    #1;
    chk("mr_vdrop", m_req_if.valid, 0);
    chk("mr_cred0", cred_cnt, 0);
    chk("mr_ovf", ovf, 0);
    chk("mr_err", err, 0);
    exp_q.delete();
    repeat (2) tick();
    areset = 1'b0;
    m_req_if.ready = 1'b1;
    watch(20);
    chk("mr_no_old", seen, 0);
    chk("mr_cred_after", cred_cnt, 0);
    chk("end_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
